// File: rtl/hist_pkg.sv
// Shared sizing and FSM encoding for the joint-histogram / L1-distance slice.
package hist_pkg;

    localparam int NUM_BINS     = 512;   // 2 CI x 16 NI x 16 RD
    localparam int BIN_W        = 16;
    localparam int ACC_W        = 25;    // BIN_W + log2(NUM_BINS)
    localparam int DRAIN_CYCLES = 3;     // pipeline depth from accept to accumulate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } hist_state_e;

endpackage

// File: rtl/ref_hist_ram.sv
// Reference histogram store: one write port, one registered read port.
module ref_hist_ram #(
    parameter  int DEPTH  = hist_pkg::NUM_BINS,
    parameter  int WIDTH  = hist_pkg::BIN_W,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: no reset on the array or read register; the reference must survive rst_n and maps to block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/hist_l1_distance.sv
// L1 distance between a streamed joint histogram and a stored reference histogram.
module hist_l1_distance #(
    parameter  int NUM_BINS = hist_pkg::NUM_BINS,
    parameter  int BIN_W    = hist_pkg::BIN_W,
    parameter  int ACC_W    = hist_pkg::ACC_W,
    localparam int ADDR_W   = $clog2(NUM_BINS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ref_we_i,
    input  logic [ADDR_W-1:0] ref_addr_i,
    input  logic [BIN_W-1:0]  ref_data_i,
    input  logic              done_i,
    input  logic [BIN_W-1:0]  cinird_i,
    input  logic              finish_i,
    output logic [ACC_W-1:0]  distance_o,
    output logic              distance_valid_o,
    output logic              bin_err_o,
    output logic              busy_o
);

    import hist_pkg::*;

    localparam int               CNT_W     = $clog2(NUM_BINS + 1);
    localparam logic [CNT_W-1:0] BIN_LIMIT = CNT_W'(NUM_BINS);

    hist_state_e       state, next_state;
    logic [1:0]        drain_cnt;
    logic [CNT_W-1:0]  bin_cnt;
    logic              overflow;
    logic              in_idle, in_accum, in_drain;
    logic              frame_start, take_bin, drain_last;

    logic              s0_valid, s1_valid, s2_valid;
    logic [ADDR_W-1:0] s0_addr;
    logic [BIN_W-1:0]  s0_data, s1_data, ref_rdata;
    logic [BIN_W:0]    s1_abs, s2_diff;
    logic [ACC_W-1:0]  acc, acc_sum;

    assign in_idle     = (state == ST_IDLE);
    assign in_accum    = (state == ST_ACCUM);
    assign in_drain    = (state == ST_DRAIN);
    assign frame_start = in_idle && (done_i || finish_i);
    // Bins past NUM_BINS are dropped; the counter holds at NUM_BINS.
    assign take_bin    = done_i && (in_idle || (in_accum && bin_cnt != BIN_LIMIT));
    assign drain_last  = in_drain && (drain_cnt == 2'(DRAIN_CYCLES - 1));

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (finish_i)    next_state = ST_DRAIN;
                else if (done_i) next_state = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (finish_i) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_last) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_o = in_accum || in_drain;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (in_drain) begin
            drain_cnt <= drain_cnt + 2'd1;
        end else begin
            drain_cnt <= '0;
        end
    end

    ref_hist_ram #(
        .DEPTH (NUM_BINS),
        .WIDTH (BIN_W)
    ) u_ref_ram (
        .clk   (clk),
        .we    (ref_we_i && in_idle),
        .waddr (ref_addr_i),
        .wdata (ref_data_i),
        .raddr (s0_addr),
        .rdata (ref_rdata)
    );

    assign s1_abs  = ({1'b0, s1_data} >= {1'b0, ref_rdata})
                   ? ({1'b0, s1_data} - {1'b0, ref_rdata})
                   : ({1'b0, ref_rdata} - {1'b0, s1_data});
    assign acc_sum = acc + (s2_valid ? ACC_W'(s2_diff) : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_cnt          <= '0;
            overflow         <= 1'b0;
            s0_valid         <= 1'b0;
            s0_addr          <= '0;
            s0_data          <= '0;
            s1_valid         <= 1'b0;
            s1_data          <= '0;
            s2_valid         <= 1'b0;
            s2_diff          <= '0;
            acc              <= '0;
            distance_o       <= '0;
            distance_valid_o <= 1'b0;
            bin_err_o        <= 1'b0;
        end else begin
            if (frame_start) begin
                bin_cnt  <= done_i ? CNT_W'(1) : '0;
                overflow <= 1'b0;
            end else if (in_accum && done_i) begin
                if (bin_cnt == BIN_LIMIT) overflow <= 1'b1;
                else                      bin_cnt  <= bin_cnt + CNT_W'(1);
            end

            s0_valid <= take_bin;
            s0_addr  <= in_idle ? '0 : bin_cnt[ADDR_W-1:0];
            s0_data  <= cinird_i;
            s1_valid <= s0_valid;
            s1_data  <= s0_data;
            s2_valid <= s1_valid;
            s2_diff  <= s1_abs;

            acc <= frame_start ? '0 : acc_sum;

            // The final bin lands in acc_sum on the same edge the result is published.
            distance_valid_o <= drain_last;
            if (drain_last) begin
                distance_o <= acc_sum;
                bin_err_o  <= (bin_cnt != BIN_LIMIT) || overflow;
            end
        end
    end

endmodule

// File: tb/tb_hist_l1_distance.sv
// Self-checking bench: randomized frames compared every cycle against a frame-level L1 model.
module tb_hist_l1_distance;

    localparam int NB    = 512;
    localparam int BIN_W = 16;
    localparam int ACC_W = 25;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             ref_we_i;
    logic [8:0]       ref_addr_i;
    logic [BIN_W-1:0] ref_data_i;
    logic             done_i;
    logic [BIN_W-1:0] cinird_i;
    logic             finish_i;
    logic [ACC_W-1:0] distance_o;
    logic             distance_valid_o;
    logic             bin_err_o;
    logic             busy_o;

    hist_l1_distance dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ref_we_i         (ref_we_i),
        .ref_addr_i       (ref_addr_i),
        .ref_data_i       (ref_data_i),
        .done_i           (done_i),
        .cinird_i         (cinird_i),
        .finish_i         (finish_i),
        .distance_o       (distance_o),
        .distance_valid_o (distance_valid_o),
        .bin_err_o        (bin_err_o),
        .busy_o           (busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // Frame-level model: reference contents, current frame, result schedule.
    int ref_m [NB];
    bit collecting    = 1'b0;
    int m_n           = 0;
    int m_sum         = 0;
    int exp_pulse_cyc = -1;
    int fin_cyc       = 0;
    int dist_old      = 0;
    int dist_new      = 0;
    bit err_old       = 1'b0;
    bit err_new       = 1'b0;
    bit chk_en        = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("distance_valid_o", 32'(distance_valid_o), 32'(cyc == exp_pulse_cyc));
            check("busy_o", 32'(busy_o), 32'(collecting || (cyc < exp_pulse_cyc)));
            check("distance_o", 32'(distance_o), 32'((cyc >= exp_pulse_cyc) ? dist_new : dist_old));
            check("bin_err_o", 32'(bin_err_o), 32'((cyc >= exp_pulse_cyc) ? err_new : err_old));
        end
    end

    // One clock of stimulus, then the model absorbs what the DUT saw at that edge.
    task automatic drive_cycle(input bit d, input int data, input bit f,
                               input bit we, input int wa, input int wd);
        bit idle_now;
        int diff;
        @(negedge clk);
        done_i     = d;
        cinird_i   = BIN_W'(data);
        finish_i   = f;
        ref_we_i   = we;
        ref_addr_i = 9'(wa);
        ref_data_i = BIN_W'(wd);
        idle_now   = !collecting && (cyc >= exp_pulse_cyc);
        @(posedge clk);
        #1;
        if (we && idle_now) ref_m[wa] = wd & 32'hFFFF;
        if (idle_now && (d || f)) begin
            collecting = 1'b1;
            m_n        = 0;
            m_sum      = 0;
        end
        if (d && collecting) begin
            m_n++;
            if (m_n <= NB) begin
                diff = (data & 32'hFFFF) - ref_m[m_n-1];
                m_sum += (diff < 0) ? -diff : diff;
            end
        end
        if (f && collecting) begin
            collecting    = 1'b0;
            fin_cyc       = cyc;
            exp_pulse_cyc = cyc + 3;
            dist_old      = dist_new;
            err_old       = err_new;
            dist_new      = m_sum;
            err_new       = (m_n != NB);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic load_ref(input int mode, input int val);
        for (int a = 0; a < NB; a++)
            drive_cycle(1'b0, 0, 1'b0, 1'b1, a,
                        (mode == 0) ? val : int'($urandom_range(0, 65535)));
    endtask

    // mode 0: every bin = val; mode 1: bin0 = val, rest 0; mode 2: random bins.
    task automatic send_frame(input int n, input int mode, input int val, input bit gaps,
                              input int wr_at, input bit fin);
        int data;
        for (int i = 0; i < n; i++) begin
            if (gaps && i > 0 && $urandom_range(0, 3) == 0)
                drive_cycle(1'b0, int'($urandom_range(0, 65535)), 1'b0, 1'($urandom_range(0, 1)),
                            int'($urandom_range(0, NB-1)), int'($urandom_range(0, 65535)));
            data = (mode == 0) ? val : (mode == 1) ? ((i == 0) ? val : 0)
                                                   : int'($urandom_range(0, 65535));
            drive_cycle(1'b1, data, fin && (i == n-1), i == wr_at, 0, 'hFFFF);
        end
        if (n == 0) drive_cycle(1'b0, 0, fin, 1'b0, 0, 0);
    endtask

    // Bounded wait for the result pulse; literal expectations pin the model.
    task automatic expect_result(input string name, input bit use_lit, input int lit_d, input bit lit_e);
        bit got = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (distance_valid_o) begin
                got = 1'b1;
                break;
            end
            idle(1);
        end
        check({name, " pulse"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " latency"}, 32'(cyc - fin_cyc), 32'd3);
            if (use_lit) begin
                check({name, " distance"}, 32'(distance_o), 32'(lit_d));
                check({name, " err"}, 32'(bin_err_o), 32'(lit_e));
            end
        end
        idle(1);
    endtask

    initial begin
        rst_n = 1'b0;
        {ref_we_i, done_i, finish_i} = '0;
        ref_addr_i = '0;
        ref_data_i = '0;
        cinird_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset distance_o", 32'(distance_o), 32'd0);
        check("reset valid", 32'(distance_valid_o), 32'd0);
        check("reset err", 32'(bin_err_o), 32'd0);
        check("reset busy", 32'(busy_o), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        load_ref(0, 0);
        send_frame(NB, 0, 1, 1'b0, -1, 1'b1);
        expect_result("all ones", 1'b1, 512, 1'b0);

        drive_cycle(1'b0, 0, 1'b0, 1'b1, 0, 10);
        send_frame(NB, 1, 3, 1'b0, -1, 1'b1);
        expect_result("abs diff", 1'b1, 7, 1'b0);

        send_frame(NB, 1, 3, 1'b0, 5, 1'b1);
        expect_result("write in accum", 1'b1, 7, 1'b0);
        send_frame(NB, 1, 3, 1'b1, -1, 1'b1);
        expect_result("ref kept", 1'b1, 7, 1'b0);

        send_frame(100, 0, 2, 1'b0, -1, 1'b1);
        expect_result("short frame", 1'b1, 206, 1'b1);
        send_frame(600, 0, 1, 1'b0, -1, 1'b1);
        expect_result("long frame", 1'b1, 520, 1'b1);

        send_frame(0, 0, 0, 1'b0, -1, 1'b1);
        expect_result("empty frame", 1'b1, 0, 1'b1);

        send_frame(NB, 0, 1, 1'b0, -1, 1'b1);
        expect_result("pre-reset frame", 1'b1, 520, 1'b0);
        send_frame(200, 0, 1, 1'b0, -1, 1'b0);
        rst_n = 1'b0;
        #1;
        check("midframe rst distance", 32'(distance_o), 32'd0);
        check("midframe rst valid", 32'(distance_valid_o), 32'd0);
        check("midframe rst busy", 32'(busy_o), 32'd0);
        collecting    = 1'b0;
        exp_pulse_cyc = -1;
        dist_old = 0; dist_new = 0;
        err_old  = 1'b0; err_new = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(6);
        send_frame(NB, 0, 1, 1'b0, -1, 1'b1);
        expect_result("post-reset frame", 1'b1, 520, 1'b0);

        for (int r = 0; r < 3; r++) begin
            load_ref(1, 0);
            for (int f = 0; f < 3; f++) begin
                send_frame((f == 2) ? int'($urandom_range(1, 700)) : NB, 2, 0, 1'b1, -1, 1'b1);
                expect_result("random frame", 1'b0, 0, 1'b0);
                idle(int'($urandom_range(0, 3)));
            end
        end

        idle(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
